// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: multi-lane fetch-to-decode pipeline register.
// It uses a valid/ready handshake and a one-entry skid buffer, so in_ready_o
// comes only from registered state. Flush clears both held bundles. A
// saturating counter records the cycles in which decode was starved.
module ifid_skid_stage #(
    parameter int LANES  = 1,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      hazard_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANES*PC_W-1:0]     in_pc_i,
    input  logic [LANES*INST_W-1:0]   in_inst_i,
    input  logic [LANES-1:0]          in_lane_v_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*PC_W-1:0]     out_pc_o,
    output logic [LANES*INST_W-1:0]   out_inst_o,
    output logic [LANES-1:0]          out_lane_v_o,
    output logic [1:0]                occupancy_o,
    output logic [CNT_W-1:0]          bubble_cnt_o
);

    // The state encoding is the number of held bundles.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [LANES*PC_W-1:0]     m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [LANES*INST_W-1:0]   m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic [LANES-1:0]          m_lv_q, m_lv_d, s_lv_q, s_lv_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic m_v, s_v, acc_in, acc_out, starved;

    // Increment that holds at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign m_v     = (state_q != EMPTY);
    assign s_v     = (state_q == FULL);
    // A bundle with an empty lane mask carries nothing, so it is never accepted.
    assign acc_in  = in_valid_i && !s_v && (|in_lane_v_i);
    // Hazard acts like decode deasserting ready.
    assign acc_out = m_v && out_ready_i && !hazard_i;
    assign starved = !m_v && out_ready_i && !hazard_i;

    // Next state and entry contents. Flush overrides every other event.
    always_comb begin
        state_d  = state_q;
        m_pc_d   = m_pc_q;
        m_inst_d = m_inst_q;
        m_lv_d   = m_lv_q;
        s_pc_d   = s_pc_q;
        s_inst_d = s_inst_q;
        s_lv_d   = s_lv_q;
        if (flush_i) begin
            state_d  = EMPTY;
            m_pc_d   = '0;
            m_inst_d = '0;
            m_lv_d   = '0;
            s_pc_d   = '0;
            s_inst_d = '0;
            s_lv_d   = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc_in) begin
                        m_pc_d   = in_pc_i;
                        m_inst_d = in_inst_i;
                        m_lv_d   = in_lane_v_i;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (acc_out && acc_in) begin
                        m_pc_d   = in_pc_i;
                        m_inst_d = in_inst_i;
                        m_lv_d   = in_lane_v_i;
                    end else if (acc_out) begin
                        // On a drain, clear the outputs so that no stale bundle is shown.
                        m_pc_d   = '0;
                        m_inst_d = '0;
                        m_lv_d   = '0;
                        state_d  = EMPTY;
                    end else if (acc_in) begin
                        s_pc_d   = in_pc_i;
                        s_inst_d = in_inst_i;
                        s_lv_d   = in_lane_v_i;
                        state_d  = FULL;
                    end
                end
                FULL: begin
                    // Input is blocked here, so only the skid entry moves forward.
                    if (acc_out) begin
                        m_pc_d   = s_pc_q;
                        m_inst_d = s_inst_q;
                        m_lv_d   = s_lv_q;
                        s_pc_d   = '0;
                        s_inst_d = '0;
                        s_lv_d   = '0;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Bubble counter: counts cycles in which decode was ready but got nothing. Flush does not clear it.
    always_comb begin
        cnt_d = starved ? sat_inc(cnt_q) : cnt_q;
    end

    // State and storage registers, cleared by asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= EMPTY;
            m_pc_q   <= '0;
            m_inst_q <= '0;
            m_lv_q   <= '0;
            s_pc_q   <= '0;
            s_inst_q <= '0;
            s_lv_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            m_pc_q   <= m_pc_d;
            m_inst_q <= m_inst_d;
            m_lv_q   <= m_lv_d;
            s_pc_q   <= s_pc_d;
            s_inst_q <= s_inst_d;
            s_lv_q   <= s_lv_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready_o   = !s_v;
    assign out_valid_o  = m_v;
    assign out_pc_o     = m_pc_q;
    assign out_inst_o   = m_inst_q;
    assign out_lane_v_o = m_lv_q;
    assign occupancy_o  = state_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage with LANES=2 and CNT_W=4.
// Each table row gives one cycle of inputs and the outputs expected after the
// next rising edge. Hand-written sequences cover the starvation count,
// counter saturation and asynchronous reset.
module tb_ifid_skid_stage;

    localparam int LANES  = 2;
    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int CNT_W  = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i, hazard_i, in_valid_i, out_ready_i;
    logic                    in_ready_o, out_valid_o;
    logic [LANES*PC_W-1:0]   in_pc_i, out_pc_o;
    logic [LANES*INST_W-1:0] in_inst_i, out_inst_o;
    logic [LANES-1:0]        in_lane_v_i, out_lane_v_o;
    logic [1:0]              occupancy_o;
    logic [CNT_W-1:0]        bubble_cnt_o;

    int checks = 0;
    int failures = 0;

    ifid_skid_stage #(.LANES(LANES), .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .hazard_i     (hazard_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_pc_i      (in_pc_i),
        .in_inst_i    (in_inst_i),
        .in_lane_v_i  (in_lane_v_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_pc_o     (out_pc_o),
        .out_inst_o   (out_inst_o),
        .out_lane_v_o (out_lane_v_o),
        .occupancy_o  (occupancy_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush;
        logic        hazard;
        logic        in_valid;
        logic [1:0]  lane_v;
        logic        ordy;
        logic [31:0] pc;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic [1:0]  exp_lv;
        logic [1:0]  exp_occ;
        logic        exp_rdy;
        logic [3:0]  exp_bub;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic fl, input logic hz, input logic iv,
                                input logic [1:0] lv, input logic ordy, input logic [31:0] pc,
                                input logic ev, input logic [31:0] epc, input logic [1:0] elv,
                                input logic [1:0] eocc, input logic erdy, input logic [3:0] ebub);
        vec_t v;
        v.flush = fl; v.hazard = hz; v.in_valid = iv; v.lane_v = lv; v.ordy = ordy; v.pc = pc;
        v.exp_v = ev; v.exp_pc = epc; v.exp_lv = elv; v.exp_occ = eocc; v.exp_rdy = erdy;
        v.exp_bub = ebub;
        return v;
    endfunction

    // Lane 1 PC is lane 0 PC + 4; each instruction word is tagged with its own PC.
    function automatic logic [63:0] pc_bus(input logic [31:0] pc);
        return {pc + 32'd4, pc};
    endfunction

    function automatic logic [63:0] inst_bus(input logic [31:0] pc);
        return {32'h1000_0000 | (pc + 32'd4), 32'h1000_0000 | pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic hz, input logic iv, input logic [1:0] lv,
                         input logic ordy, input logic [31:0] pc);
        flush_i     = fl;
        hazard_i    = hz;
        in_valid_i  = iv;
        in_lane_v_i = lv;
        out_ready_i = ordy;
        in_pc_i     = pc_bus(pc);
        in_inst_i   = inst_bus(pc);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Streaming A, B, C with decode ready.
        tbl[0]  = mk(0,0,1,2'b11,1,32'h100, 1,32'h100,2'b11,2'd1,1,4'd1);
        tbl[1]  = mk(0,0,1,2'b11,1,32'h200, 1,32'h200,2'b11,2'd1,1,4'd1);
        tbl[2]  = mk(0,0,1,2'b11,1,32'h300, 1,32'h300,2'b11,2'd1,1,4'd1);
        tbl[3]  = mk(0,0,0,2'b00,1,32'h000, 0,32'h000,2'b00,2'd0,1,4'd1);
        // Hazard for 3 cycles while pushing D, E, F; F blocked until release.
        tbl[4]  = mk(0,1,1,2'b11,1,32'h400, 1,32'h400,2'b11,2'd1,1,4'd1);
        tbl[5]  = mk(0,1,1,2'b11,1,32'h500, 1,32'h400,2'b11,2'd2,0,4'd1);
        tbl[6]  = mk(0,1,1,2'b11,1,32'h600, 1,32'h400,2'b11,2'd2,0,4'd1);
        tbl[7]  = mk(0,0,1,2'b11,1,32'h600, 1,32'h500,2'b11,2'd1,1,4'd1);
        tbl[8]  = mk(0,0,1,2'b11,1,32'h600, 1,32'h600,2'b11,2'd1,1,4'd1);
        tbl[9]  = mk(0,0,0,2'b00,1,32'h000, 0,32'h000,2'b00,2'd0,1,4'd1);
        // Fill to FULL, then flush with a valid input present.
        tbl[10] = mk(0,0,1,2'b11,0,32'h700, 1,32'h700,2'b11,2'd1,1,4'd1);
        tbl[11] = mk(0,0,1,2'b11,0,32'h800, 1,32'h700,2'b11,2'd2,0,4'd1);
        tbl[12] = mk(1,0,1,2'b11,0,32'h900, 0,32'h000,2'b00,2'd0,1,4'd1);
        tbl[13] = mk(0,0,1,2'b11,0,32'hA00, 1,32'hA00,2'b11,2'd1,1,4'd1);
        // Zero lane mask is ignored.
        tbl[14] = mk(0,0,1,2'b00,0,32'hB00, 1,32'hA00,2'b11,2'd1,1,4'd1);
        tbl[15] = mk(0,0,0,2'b00,1,32'h000, 0,32'h000,2'b00,2'd0,1,4'd1);
        // Flush together with hazard: flush wins.
        tbl[16] = mk(0,0,1,2'b11,0,32'hC00, 1,32'hC00,2'b11,2'd1,1,4'd1);
        tbl[17] = mk(1,1,0,2'b00,0,32'h000, 0,32'h000,2'b00,2'd0,1,4'd1);
        // Partial lane mask carried through.
        tbl[18] = mk(0,0,1,2'b10,0,32'hD00, 1,32'hD00,2'b10,2'd1,1,4'd1);
        tbl[19] = mk(1,0,0,2'b00,0,32'h000, 0,32'h000,2'b00,2'd0,1,4'd1);

        // Reset
        drive(0,0,0,2'b00,0,32'h0);
        rst_i = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_occ",   64'(occupancy_o), 64'd0);
        chk("rst_rdy",   64'(in_ready_o),  64'd1);
        chk("rst_bub",   64'(bubble_cnt_o), 64'd0);
        chk("rst_pc",    64'(out_pc_o),    64'd0);
        rst_i = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            logic [63:0] epc, einst;
            drive(tbl[i].flush, tbl[i].hazard, tbl[i].in_valid, tbl[i].lane_v, tbl[i].ordy, tbl[i].pc);
            step();
            epc   = tbl[i].exp_v ? pc_bus(tbl[i].exp_pc)   : 64'd0;
            einst = tbl[i].exp_v ? inst_bus(tbl[i].exp_pc) : 64'd0;
            chk($sformatf("r%0d_valid", i), 64'(out_valid_o),  64'(tbl[i].exp_v));
            chk($sformatf("r%0d_pc", i),    64'(out_pc_o),     epc);
            chk($sformatf("r%0d_inst", i),  64'(out_inst_o),   einst);
            chk($sformatf("r%0d_lanev", i), 64'(out_lane_v_o), 64'(tbl[i].exp_lv));
            chk($sformatf("r%0d_occ", i),   64'(occupancy_o),  64'(tbl[i].exp_occ));
            chk($sformatf("r%0d_rdy", i),   64'(in_ready_o),   64'(tbl[i].exp_rdy));
            chk($sformatf("r%0d_bub", i),   64'(bubble_cnt_o), 64'(tbl[i].exp_bub));
        end

        // Zero-mask pushes while starved for 5 cycles: counter goes from 1 to 6, stage stays empty.
        for (int i = 0; i < 5; i++) begin
            drive(0,0,1,2'b00,1,32'hE00);
            step();
            chk($sformatf("zm%0d_occ", i), 64'(occupancy_o), 64'd0);
        end
        chk("zm_bub", 64'(bubble_cnt_o), 64'd6);

        // Starve 20 more cycles: counter saturates at 15.
        drive(0,0,0,2'b00,1,32'h0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_bub", 64'(bubble_cnt_o), 64'd15);
        drive(1,0,0,2'b00,0,32'h0);
        step();
        chk("sat_flush_bub", 64'(bubble_cnt_o), 64'd15);

        // Reach FULL, then assert asynchronous reset mid-cycle.
        drive(0,0,1,2'b11,0,32'hF00);
        step();
        drive(0,0,1,2'b11,0,32'hF10);
        step();
        chk("pre_arst_occ", 64'(occupancy_o), 64'd2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid_o),  64'd0);
        chk("arst_occ",   64'(occupancy_o),  64'd0);
        chk("arst_rdy",   64'(in_ready_o),   64'd1);
        chk("arst_bub",   64'(bubble_cnt_o), 64'd0);
        chk("arst_pc",    64'(out_pc_o),     64'd0);
        #2;
        rst_i = 1'b0;
        drive(0,0,1,2'b11,0,32'h1200);
        step();
        chk("post_arst_pc",  64'(out_pc_o),    pc_bus(32'h1200));
        chk("post_arst_occ", 64'(occupancy_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
